// File: rtl/tpu_pkg.sv
// tpu_pkg: shared constants, FSM state encoding and result lane conversion for the OS systolic array
package tpu_pkg;
  localparam int TPU_DIM    = 4;
  localparam int TPU_DATA_W = 8;
  localparam int TPU_ACC_W  = 32;
  localparam int TPU_OUT_W  = 8;
  localparam int TPU_DIM_W  = 8;
  localparam int TPU_IDX_W  = 16;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  function automatic logic signed [63:0] sat_lane(input logic signed [63:0] acc, input int out_w, input logic sat);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return !sat ? acc : acc > hi ? hi : acc < lo ? lo : acc;
  endfunction
endpackage

// File: rtl/tpu_os_pe.sv
// tpu_os_pe: signed MAC processing element with registered a/b pass-through
module tpu_os_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     go,
  input  logic [DATA_W-1:0]        a_in,
  input  logic [DATA_W-1:0]        b_in,
  output logic [DATA_W-1:0]        a_out,
  output logic [DATA_W-1:0]        b_out,
  output logic signed [ACC_W-1:0]  acc
);
  logic signed [2*DATA_W-1:0] prod;
  assign prod = $signed(a_in) * $signed(b_in);
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      if (go) acc <= acc + ACC_W'(prod);
    end
  end
endmodule

// File: rtl/tpu_os_array.sv
// tpu_os_array: parametrised output-stationary systolic matmul engine with buffer-driven tiling
module tpu_os_array
  import tpu_pkg::*;
#(
  parameter int ARRAY_DIM = TPU_DIM,
  parameter int DATA_W    = TPU_DATA_W,
  parameter int ACC_W     = TPU_ACC_W,
  parameter int OUT_W     = TPU_OUT_W,
  parameter int DIM_W     = TPU_DIM_W,
  parameter int IDX_W     = TPU_IDX_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [DIM_W-1:0]            m,
  input  logic [DIM_W-1:0]            n,
  input  logic [DIM_W-1:0]            k,
  input  logic                        sat_en,
  output logic                        wr_en_a,
  output logic                        wr_en_b,
  output logic [IDX_W-1:0]            index_a,
  output logic [IDX_W-1:0]            index_b,
  input  logic [ARRAY_DIM*DATA_W-1:0] data_in_a,
  input  logic [ARRAY_DIM*DATA_W-1:0] data_in_b,
  output logic                        wr_en_o,
  output logic [IDX_W-1:0]            index_o,
  output logic [ARRAY_DIM*OUT_W-1:0]  data_out_o,
  output logic                        busy,
  output logic                        done
);
  localparam int D  = ARRAY_DIM;
  localparam int RW = $clog2(D);
  logic [2:0] state;
  logic [DIM_W-1:0] m_r, n_r, k_r, mt, nt;
  logic sat_r;
  logic [IDX_W-1:0] cnt, row_base, col_base;
  logic clear, go, feed_v, last_row, more_mt, more_nt;
  logic [DATA_W-1:0] feed_a [D];
  logic [DATA_W-1:0] feed_b [D];
  logic [DATA_W-1:0] a_h [D][D+1];
  logic [DATA_W-1:0] b_h [D+1][D];
  logic signed [ACC_W-1:0] acc_h [D][D];
  assign row_base = IDX_W'(mt) * IDX_W'(D);
  assign col_base = IDX_W'(nt) * IDX_W'(D);
  assign clear    = state == S_CLEAR;
  assign go       = state == S_FEED || state == S_DRAIN;
  // word kk-1 arrives while cnt == kk, so the first FEED cycle injects zeros
  assign feed_v   = state == S_FEED && cnt != '0;
  assign last_row = (row_base + cnt + 1'b1 >= IDX_W'(m_r)) || cnt == IDX_W'(D - 1);
  assign more_mt  = row_base + IDX_W'(D) < IDX_W'(m_r);
  assign more_nt  = col_base + IDX_W'(D) < IDX_W'(n_r);
  assign busy     = state == S_CLEAR || state == S_FEED || state == S_DRAIN || state == S_WRITE;
  assign done     = state == S_DONE;
  assign wr_en_a  = 1'b0;
  assign wr_en_b  = 1'b0;
  assign wr_en_o  = state == S_WRITE;
  assign index_a  = state == S_FEED && cnt < IDX_W'(k_r) ? IDX_W'(mt) * IDX_W'(k_r) + cnt : '0;
  assign index_b  = state == S_FEED && cnt < IDX_W'(k_r) ? IDX_W'(nt) * IDX_W'(k_r) + cnt : '0;
  assign index_o  = state == S_WRITE ? IDX_W'(nt) * IDX_W'(m_r) + row_base + cnt : '0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      mt    <= '0;
      nt    <= '0;
      m_r   <= '0;
      n_r   <= '0;
      k_r   <= '0;
      sat_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) begin
          m_r   <= m;
          n_r   <= n;
          k_r   <= k;
          sat_r <= sat_en;
          mt    <= '0;
          nt    <= '0;
          cnt   <= '0;
          state <= (m == '0 || n == '0 || k == '0) ? S_DONE : S_CLEAR;
        end
        S_CLEAR: begin
          cnt   <= '0;
          state <= S_FEED;
        end
        S_FEED: begin
          cnt   <= cnt == IDX_W'(k_r) ? '0 : cnt + 1'b1;
          state <= cnt == IDX_W'(k_r) ? S_DRAIN : S_FEED;
        end
        S_DRAIN: begin
          cnt   <= cnt == IDX_W'(2 * D - 2) ? '0 : cnt + 1'b1;
          state <= cnt == IDX_W'(2 * D - 2) ? S_WRITE : S_DRAIN;
        end
        S_WRITE: if (last_row) begin
          cnt   <= '0;
          mt    <= more_mt ? mt + 1'b1 : '0;
          nt    <= !more_mt && more_nt ? nt + 1'b1 : nt;
          state <= more_mt || more_nt ? S_CLEAR : S_DONE;
        end else cnt <= cnt + 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end
  for (genvar i = 0; i < D; i++) begin : g_lane
    assign feed_a[i] = feed_v && row_base + IDX_W'(i) < IDX_W'(m_r) ? data_in_a[(D-1-i)*DATA_W +: DATA_W] : '0;
    assign feed_b[i] = feed_v && col_base + IDX_W'(i) < IDX_W'(n_r) ? data_in_b[(D-1-i)*DATA_W +: DATA_W] : '0;
    if (i == 0) begin : g_d0
      assign a_h[0][0] = feed_a[0];
      assign b_h[0][0] = feed_b[0];
    end else begin : g_dn
      logic [DATA_W-1:0] qa [i];
      logic [DATA_W-1:0] qb [i];
      always_ff @(posedge clk) begin
        if (!rst || clear) begin
          for (int s = 0; s < i; s++) begin
            qa[s] <= '0;
            qb[s] <= '0;
          end
        end else begin
          qa[0] <= feed_a[i];
          qb[0] <= feed_b[i];
          for (int s = 1; s < i; s++) begin
            qa[s] <= qa[s-1];
            qb[s] <= qb[s-1];
          end
        end
      end
      assign a_h[i][0] = qa[i-1];
      assign b_h[0][i] = qb[i-1];
    end
  end
  for (genvar i = 0; i < D; i++) begin : g_row
    for (genvar j = 0; j < D; j++) begin : g_col
      tpu_os_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .go    (go),
        .a_in  (a_h[i][j]),
        .b_in  (b_h[i][j]),
        .a_out (a_h[i][j+1]),
        .b_out (b_h[i+1][j]),
        .acc   (acc_h[i][j])
      );
    end
  end
  always_comb begin
    data_out_o = '0;
    for (int c = 0; c < D; c++)
      data_out_o[(D-1-c)*OUT_W +: OUT_W] = state == S_WRITE && col_base + IDX_W'(c) < IDX_W'(n_r)
        ? OUT_W'(sat_lane(64'(acc_h[cnt[RW-1:0]][c]), OUT_W, sat_r)) : '0;
  end
endmodule

// File: tb/tb_tpu_os_array.sv
// tb_tpu_os_array: directed self-checking bench for the OS systolic array
module tb_tpu_os_array;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, sat_en = 1'b0;
  logic [7:0] m = '0, n = '0, k = '0;
  logic wr_en_a, wr_en_b, wr_en_o, busy, done;
  logic [15:0] index_a, index_b, index_o;
  logic [31:0] data_in_a = '0, data_in_b = '0, data_out_o;
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] cap [64];
  logic signed [7:0] ea [6][3];
  logic signed [7:0] eb [3][5];
  int vecs = 0, fails = 0, nwr = 0, lat;

  always #5 clk = ~clk;

  tpu_os_array dut (
    .clk(clk), .rst(rst), .start(start), .m(m), .n(n), .k(k), .sat_en(sat_en),
    .wr_en_a(wr_en_a), .wr_en_b(wr_en_b), .index_a(index_a), .index_b(index_b),
    .data_in_a(data_in_a), .data_in_b(data_in_b), .wr_en_o(wr_en_o), .index_o(index_o),
    .data_out_o(data_out_o), .busy(busy), .done(done)
  );

  always @(posedge clk) begin
    data_in_a <= mem_a[index_a[7:0]];
    data_in_b <= mem_b[index_b[7:0]];
  end

  always @(negedge clk)
    if (wr_en_o) begin
      if (index_o < 16'd64) cap[index_o[5:0]] = data_out_o;
      nwr++;
    end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run(input int mm, input int nn, input int kk, input logic sat, input int poke, output int l);
    @(negedge clk);
    for (int i = 0; i < 64; i++) cap[i] = 32'hDEADBEEF;
    nwr = 0;
    m = 8'(mm); n = 8'(nn); k = 8'(kk); sat_en = sat; start = 1'b1;
    l = -1;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      start = (c == poke);
      if (c == poke) begin m = 8'd1; n = 8'd1; k = 8'd1; end
      if (done) begin l = c - 1; break; end
    end
    start = 1'b0;
    chk("done_seen", done, 1);
  endtask

  task automatic load_identity();
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = {8'(i == 0), 8'(i == 1), 8'(i == 2), 8'(i == 3)};
      mem_b[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    end
  endtask

  task automatic check_identity(input string tag);
    chk({tag, "_writes"}, nwr, 4);
    for (int i = 0; i < 4; i++) chk(tag, cap[i], {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)});
  endtask

  initial begin
    int s;
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {wr_en_a, wr_en_b, wr_en_o, busy, done}, 0);
    chk("rst_idx", {index_a, index_b, index_o}, 0);
    chk("rst_data", data_out_o, 0);
    rst = 1'b1;

    run(4, 4, 0, 1'b0, 0, lat);
    chk("zero_lat", lat, 0);
    chk("zero_busy", busy, 0);
    repeat (5) @(negedge clk);
    chk("zero_writes", nwr, 0);

    load_identity();
    run(4, 4, 4, 1'b0, 5, lat);
    chk("ident_lat", lat, 17);
    check_identity("ident");

    for (int i = 0; i < 9; i++) begin mem_a[i] = 32'h01010101; mem_b[i] = 32'h01010101; end
    run(4, 4, 9, 1'b0, 0, lat);
    repeat (5) @(negedge clk);
    chk("deepk_writes", nwr, 4);
    for (int i = 0; i < 4; i++) chk("deepk", cap[i], 32'h09090909);

    for (int r = 0; r < 6; r++) for (int kk = 0; kk < 3; kk++) ea[r][kk] = 8'($urandom_range(0, 255));
    for (int kk = 0; kk < 3; kk++) for (int c = 0; c < 5; c++) eb[kk][c] = 8'($urandom_range(0, 255));
    for (int t = 0; t < 2; t++)
      for (int kk = 0; kk < 3; kk++) begin
        for (int l = 0; l < 4; l++) begin
          w[(3-l)*8 +: 8] = (t*4 + l < 6) ? ea[t*4+l][kk] : 8'hA5;
          mem_a[t*3+kk][(3-l)*8 +: 8] = w[(3-l)*8 +: 8];
          mem_b[t*3+kk][(3-l)*8 +: 8] = (t*4 + l < 5) ? eb[kk][t*4+l] : 8'h5A;
        end
      end
    run(6, 5, 3, 1'b0, 0, lat);
    chk("edge_writes", nwr, 12);
    for (int t = 0; t < 2; t++)
      for (int r = 0; r < 6; r++) begin
        for (int l = 0; l < 4; l++) begin
          s = 0;
          for (int kk = 0; kk < 3; kk++)
            if (t*4 + l < 5) s += int'(ea[r][kk]) * int'(eb[kk][t*4+l]);
          w[(3-l)*8 +: 8] = s[7:0];
        end
        chk("edge", cap[t*6+r], w);
      end

    for (int i = 0; i < 4; i++) begin mem_a[i] = 32'h7F7F7F7F; mem_b[i] = 32'h7F7F7F7F; end
    run(4, 4, 4, 1'b1, 0, lat);
    for (int i = 0; i < 4; i++) chk("sat_on", cap[i], 32'h7F7F7F7F);
    run(4, 4, 4, 1'b0, 0, lat);
    for (int i = 0; i < 4; i++) chk("sat_off", cap[i], 32'h04040404);

    load_identity();
    @(negedge clk);
    m = 8'd4; n = 8'd4; k = 8'd4; sat_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("feed_busy", busy, 1);
    nwr = 0;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ctrl", {wr_en_a, wr_en_b, wr_en_o, busy, done}, 0);
    chk("midrst_idx", {index_a, index_b, index_o}, 0);
    chk("midrst_data", data_out_o, 0);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("midrst_nowrite", nwr, 0);
    chk("midrst_idle", {busy, done}, 0);
    run(4, 4, 4, 1'b0, 0, lat);
    chk("post_rst_lat", lat, 17);
    check_identity("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule

// File: doc/tpu_os_array.md
Name: tpu_os_array

Overview:
- Parametrised successor to the fixed 4x4 TPU: an ARRAY_DIM x ARRAY_DIM output-stationary systolic matrix-multiply engine computing C = A(MxK) x B(KxN).
- Reads A and B words from the global buffers and writes C rows back to the output buffer.
- Adds over the fixed block: signed operands, any K without re-tiling, partial M/N edge tiles, an optional saturation mode, and a start/busy/done handshake.

Parameters:
- ARRAY_DIM, 4: PE rows = PE columns = lanes per buffer word.
- DATA_W, 8: signed operand width per lane.
- ACC_W, 32: internal PE accumulator width.
- OUT_W, 8: result lane width in output words.
- DIM_W, 8: width of the m/n/k size inputs.
- IDX_W, 16: buffer index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  start pulse; sampled only in IDLE/DONE
- m, n, k  in  DIM_W each  matrix sizes
- sat_en  in  1  1 = saturate results, 0 = truncate; sampled at start
- wr_en_a, wr_en_b  out  1 each  buffer write enables; tied 0 (read only)
- index_a, index_b  out  IDX_W each  A/B read address
- data_in_a, data_in_b  in  ARRAY_DIM*DATA_W each  read data; lane 0 = MSBs
- wr_en_o  out  1  output write strobe
- index_o  out  IDX_W  output write address
- data_out_o  out  ARRAY_DIM*OUT_W  output word
- busy  out  1  high from start acceptance to DONE entry
- done  out  1  high in DONE until the next start is accepted

Behaviour:
- Reset: one clock, synchronous, active-low (rst=0 resets on the clk edge). All outputs 0; state IDLE; accumulators cleared. Reset mid-operation aborts with no further writes.
- Buffer layout, D = ARRAY_DIM, MT = ceil(M/D), NT = ceil(N/D):
  - A word (mt*K + kk) holds A[mt*D+r][kk] in lane r.
  - B word (nt*K + kk) holds B[kk][nt*D+c] in lane c.
  - C word (nt*M + row) holds C[row][nt*D+c] in lane c.
  - Out-of-range lanes in A/B are don't-care and masked to 0 on input.
  - Out-of-range output lanes are written as 0.
- Read latency: data valid 1 cycle after the index is presented.
- FSM:
  - IDLE: start=1 latches m, n, k and sat_en, sets busy, goes to CLEAR. If any of m, n, k is 0, goes straight to DONE with no writes.
  - CLEAR: 1 cycle; zero all accumulators and the skew registers.
  - FEED: K+1 cycles. Issues indices kk = 0..K-1. The returned A lane r passes through r skew registers before row r; B lane c passes through c skew registers before column c.
  - DRAIN: 2*D-1 cycles with zero operands injected, until PE[D-1][D-1] holds its K-th product.
  - WRITE: one word per cycle for rows mt*D .. min(mt*D+D, M)-1. wr_en_o=1, index_o = nt*M + row.
  - Tile order: mt inner, nt outer. After the last tile, go to DONE; otherwise go to CLEAR.
  - DONE: done=1, busy=0. A new start is accepted here as in IDLE.
- PE: a_out/b_out are registered pass-through; acc += a_in*b_in when the go flag is set; products are signed.
- Result lane conversion:
  - sat_en=0: low OUT_W bits of acc (wrap).
  - sat_en=1: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- start while busy is ignored. Accumulator overflow beyond ACC_W wraps silently.
- Cycles per tile = 1 + (K+1) + (2D-1) + rows_in_tile.

Decomposition:
- Package tpu_pkg: state encoding (IDLE, CLEAR, FEED, DRAIN, WRITE, DONE), default parameter constants, and a lane-extract/saturate function.
- Sub-module tpu_os_pe: one MAC PE (clear, go, a/b pass-through, acc out), instantiated D*D times via generate.
- Skew registers and the FSM stay in the top module.

Test Plan:
- Identity: D=4, M=N=K=4, A=I, B[i][j]=i*4+j, sat_en=0 -> C == B at indices 0..3; done rises exactly 1+5+7+4=17 cycles after start.
- Deep K: M=N=4, K=9, all ones -> every lane 9, words 0..3, no extra writes.
- Edge tiles: M=6, N=5, K=3, random signed -> 12 writes to indices 0..11; lanes beyond column 4 are 0; all other lanes match the golden model.
- Saturation: A all 127, B all 127, K=4; sat_en=1 -> lanes 0x7F. Same stimulus with sat_en=0 -> lanes 0x04 (64516 mod 256).
- Zero size: k=0, start -> done next cycle, wr_en_o never asserted; a second start while busy in a normal run is ignored.
- Reset: rst=0 for one cycle during FEED -> next edge all outputs 0, IDLE; a fresh start then produces a correct identity result.
